wall_probe: RTL and testbench

//  Upstream of the player-motion block: once per frame, samples the tile map around the

---
 rtl/wall_probe_if.sv | 11 +
 rtl/wall_probe.sv | 197 +++++++++++++++++++
 tb/tb_wall_probe.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wall_probe_if.sv
// Tile-map ROM read port used by wall_probe.
// wall_probe (master) drives one address per cycle. The ROM (slave) returns the
// tile code in the following cycle:
//   00 = empty, 01 = solid, 1x = hazard.
interface wall_probe_if;
  logic [10:0] map_addr;
  logic [1:0]  map_data;

  modport master (output map_addr, input  map_data);
  modport slave  (input  map_addr, output map_data);
endinterface

// File: rtl/wall_probe.sv
// wall_probe: once per frame, samples the tile map around the player box and
// produces the side-clearance codes that gate player motion.
//   Code values: 0 = blocked, 1 = clear, 2 = hazard.
//
// Sweep timing, counted from the frame_start edge N:
//   - Probe addresses are issued on edges N+1 .. N+P.
//   - The data for each address is captured on the following edge.
//   - All four side codes change together on edge N+P+2.
//   - probe_done is a one-cycle pulse in the cycle after that edge.
//
// Build option PROBE_MID_EN (macro):
//   - Defined:   each side also samples its midpoint, so P = 12.
//   - Undefined: two corner samples per side, so P = 8.
module wall_probe #(
  parameter int BALL_S     = 13,   // player half-size (px)
  parameter int STEP_X     = 3,    // horizontal look-ahead (px)
  parameter int STEP_Y     = 5,    // upward look-ahead (px)
  parameter int GRAV       = 2,    // downward look-ahead (px)
  parameter int TILE_SHIFT = 4,    // log2 tile size
  parameter int MAP_COLS   = 40,   // tiles per map row
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         frame_start,
  input  logic [9:0]   BallX,
  input  logic [9:0]   BallY,
  wall_probe_if.master bus,
  output logic [2:0]   wLeft,
  output logic [2:0]   wRight,
  output logic [2:0]   wTop,
  output logic [2:0]   wBottom,
  output logic         probe_done,
  output logic         overrun
);

`ifdef PROBE_MID_EN
  localparam logic [1:0] LAST_SLOT = 2'd2;   // low end, high end, midpoint
`else
  localparam logic [1:0] LAST_SLOT = 2'd1;   // low end, high end
`endif

  localparam logic signed [10:0] OUT_X = 11'(BALL_S + STEP_X);
  localparam logic signed [10:0] IN_S  = 11'(BALL_S - 1);
  localparam logic signed [10:0] UP_Y  = 11'(BALL_S + STEP_Y);
  localparam logic signed [10:0] DN_Y  = 11'(BALL_S + GRAV);
  localparam logic signed [10:0] SCR_W = 11'(SCREEN_W);
  localparam logic signed [10:0] SCR_H = 11'(SCREEN_H);
  localparam logic [10:0]        COLS  = 11'(MAP_COLS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_COMMIT} state_t;
  typedef enum logic [1:0] {SIDE_L, SIDE_R, SIDE_T, SIDE_B} side_t;

  state_t             state, state_nxt;
  logic signed [10:0] ball_x, ball_y;     // player position frozen for the sweep
  side_t              side_cnt;           // side currently being issued
  logic [1:0]         slot_cnt;           // sample index along that side
  logic               last_probe;
  logic signed [10:0] along;              // offset along the side's edge
  logic signed [10:0] probe_x, probe_y;
  logic               probe_oob;
  logic [10:0]        tile_row, tile_col, probe_addr;
  logic [10:0]        map_addr_q;
  logic               cap_vld, cap_oob;   // sample in flight, returns next cycle
  side_t              cap_side;
  logic [3:0]         solid_acc, haz_acc; // per-side sticky flags, bit = side_t

  function automatic logic [2:0] side_code(input logic solid, input logic haz);
    if (solid) return 3'd0;
    if (haz)   return 3'd2;
    return 3'd1;
  endfunction

  assign last_probe   = (side_cnt == SIDE_B) && (slot_cnt == LAST_SLOT);
  assign bus.map_addr = map_addr_q;

  // Probe coordinate for the current side and slot.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    along   = '0;
    probe_x = ball_x;
    probe_y = ball_y;
    case (slot_cnt)
      2'd0:    along = -IN_S;
      2'd1:    along = IN_S;
      default: along = '0;   // midpoint slot, only reached with PROBE_MID_EN
    endcase
    case (side_cnt)
      SIDE_L: begin probe_x = ball_x - OUT_X; probe_y = ball_y + along; end
      SIDE_R: begin probe_x = ball_x + OUT_X; probe_y = ball_y + along; end
      SIDE_T: begin probe_x = ball_x + along; probe_y = ball_y - UP_Y;  end
      SIDE_B: begin probe_x = ball_x + along; probe_y = ball_y + DN_Y;  end
      default: ;
    endcase
  end

  // Off-screen test and tile address.
  // The multiply by MAP_COLS is by a constant, so it reduces to shifts and adds.
  assign probe_oob  = probe_x[10] | probe_y[10] | (probe_x >= SCR_W) | (probe_y >= SCR_H);
  assign tile_row   = $unsigned(probe_y) >> TILE_SHIFT;
  assign tile_col   = $unsigned(probe_x) >> TILE_SHIFT;
  assign probe_addr = tile_row * COLS + tile_col;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so that every register
  //       samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Sweep sequencing: IDLE -> ISSUE (one cycle per probe) -> DRAIN -> COMMIT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (frame_start) state_nxt = S_ISSUE;
      S_ISSUE:  if (last_probe)  state_nxt = S_DRAIN;
      S_DRAIN:  state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch the ball position, issue addresses, commit the codes,
  // and flag overruns.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ball_x     <= '0;
      ball_y     <= '0;
      side_cnt   <= SIDE_L;
      slot_cnt   <= '0;
      map_addr_q <= '0;
      cap_vld    <= 1'b0;
      cap_oob    <= 1'b0;
      cap_side   <= SIDE_L;
      wLeft      <= 3'd0;
      wRight     <= 3'd0;
      wTop       <= 3'd0;
      wBottom    <= 3'd0;
      probe_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      probe_done <= 1'b0;
      cap_vld    <= 1'b0;
      // A start request while a sweep is running (COMMIT included) is dropped
      // and flagged.
      if (frame_start && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: if (frame_start) begin
          ball_x   <= {1'b0, BallX};
          ball_y   <= {1'b0, BallY};
          side_cnt <= SIDE_L;
          slot_cnt <= '0;
        end
        S_ISSUE: begin
          // An off-screen probe leaves the bus address unchanged and is
          // scored as solid.
          if (!probe_oob) map_addr_q <= probe_addr;
          cap_vld  <= 1'b1;
          cap_oob  <= probe_oob;
          cap_side <= side_cnt;
          if (slot_cnt == LAST_SLOT) begin
            slot_cnt <= '0;
            side_cnt <= side_t'(side_cnt + 2'd1);
          end else begin
            slot_cnt <= slot_cnt + 2'd1;
          end
        end
        S_COMMIT: begin
          wLeft      <= side_code(solid_acc[SIDE_L], haz_acc[SIDE_L]);
          wRight     <= side_code(solid_acc[SIDE_R], haz_acc[SIDE_R]);
          wTop       <= side_code(solid_acc[SIDE_T], haz_acc[SIDE_T]);
          wBottom    <= side_code(solid_acc[SIDE_B], haz_acc[SIDE_B]);
          probe_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-side accumulation of returned samples.
  // Solid dominates hazard, and hazard dominates empty.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      solid_acc <= '0;
      haz_acc   <= '0;
    end else if (state == S_IDLE && frame_start) begin
      solid_acc <= '0;
      haz_acc   <= '0;
    end else if (cap_vld) begin
      if (cap_oob || bus.map_data == 2'b01) solid_acc[cap_side] <= 1'b1;
      else if (bus.map_data[1])             haz_acc[cap_side]   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wall_probe.sv
// Self-checking bench for wall_probe.
//
// The tile ROM is modelled by the bench: map_data follows map_addr within the
// same cycle.
//
// The reference model is built from the side/probe geometry rules. It predicts:
//   - every in-screen address issued during a sweep,
//   - the committed side codes,
//   - the probe_done pulse,
//   - the overrun flag.
// A single compare process checks the DUT against the model on every falling edge.
module tb_wall_probe;
  localparam int BS = 13, SX = 3, SY = 5, GR = 2;
`ifdef PROBE_MID_EN
  localparam int PER_SIDE = 3;
  localparam logic [31:0] LEDGE_CODES = 32'o0111;
`else
  localparam int PER_SIDE = 2;
  localparam logic [31:0] LEDGE_CODES = 32'o1111;
`endif
  localparam int NP    = 4 * PER_SIDE;
  localparam int TILES = 1200;

  logic       Clk, Reset_n, frame_start;
  logic [9:0] BallX, BallY;
  logic [2:0] wLeft, wRight, wTop, wBottom;
  logic       probe_done, overrun;

  wall_probe_if bus ();
  logic [1:0] rom [TILES];
  assign bus.map_data = (bus.map_addr < 11'(TILES)) ? rom[bus.map_addr] : 2'b01;

  wall_probe dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .BallX       (BallX),
    .BallY       (BallY),
    .bus         (bus),
    .wLeft       (wLeft),
    .wRight      (wRight),
    .wTop        (wTop),
    .wBottom     (wBottom),
    .probe_done  (probe_done),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (o%0o), expected %0d (o%0o) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] codes();
    return 32'({wLeft, wRight, wTop, wBottom});
  endfunction

  // ---------------- reference model ----------------
  function automatic bit off_screen(input int x, input int y);
    return (x < 0) || (y < 0) || (x >= 640) || (y >= 480);
  endfunction

  function automatic int tile_addr(input int x, input int y);
    return (y / 16) * 40 + (x / 16);
  endfunction

  // Position along an edge.
  //   k = 0: low end.
  //   k = 1: high end.
  //   k = 2: centre.
  function automatic int edge_pos(input int c, input int k);
    if (k == 0) return c - (BS - 1);
    if (k == 1) return c + (BS - 1);
    return c;
  endfunction

  // Sides: 0 = left, 1 = right, 2 = top, 3 = bottom.
  function automatic int pt_x(input int s, input int k, input int bx);
    if (s == 0) return bx - (BS + SX);
    if (s == 1) return bx + (BS + SX);
    return edge_pos(bx, k);
  endfunction

  function automatic int pt_y(input int s, input int k, input int by);
    if (s == 2) return by - (BS + SY);
    if (s == 3) return by + (BS + GR);
    return edge_pos(by, k);
  endfunction

  typedef struct {int c; int a;} addr_exp_t;
  addr_exp_t aq[$];
  int        cyc        = 0;
  bit        busy       = 0;
  int        commit_cyc = 0;
  int        exp_w[4]   = '{default: 0};
  int        pend[4]    = '{default: 0};
  bit        exp_done   = 0;
  bit        exp_ovr    = 0;
  bit        cmp_en     = 0;

  task automatic model_start(input int bx, input int by);
    for (int s = 0; s < 4; s++) begin
      bit solid, haz;
      solid = 0;
      haz   = 0;
      for (int k = 0; k < PER_SIDE; k++) begin
        int x, y, a;
        x = pt_x(s, k, bx);
        y = pt_y(s, k, by);
        if (off_screen(x, y)) begin
          solid = 1;
        end else begin
          a = tile_addr(x, y);
          aq.push_back('{cyc + 1 + s * PER_SIDE + k, a});
          if (rom[a] == 2'b01) solid = 1;
          else if (rom[a][1])  haz = 1;
        end
      end
      pend[s] = solid ? 0 : (haz ? 2 : 1);
    end
  endtask

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy     = 0;
      exp_w    = '{default: 0};
      exp_done = 0;
      exp_ovr  = 0;
      aq.delete();
    end else begin
      cyc++;
      exp_done = 0;
      if (busy) begin
        if (frame_start) exp_ovr = 1;
        if (cyc == commit_cyc) begin
          exp_w    = pend;
          exp_done = 1;
          busy     = 0;
        end
      end else if (frame_start) begin
        busy       = 1;
        commit_cyc = cyc + NP + 2;
        model_start(int'(BallX), int'(BallY));
      end
    end
  end

  // Compare DUT against the model, away from the active edge.
  always @(negedge Clk) begin
    if (cmp_en) begin
      check("wLeft",      32'(wLeft),      exp_w[0]);
      check("wRight",     32'(wRight),     exp_w[1]);
      check("wTop",       32'(wTop),       exp_w[2]);
      check("wBottom",    32'(wBottom),    exp_w[3]);
      check("probe_done", 32'(probe_done), 32'(exp_done));
      check("overrun",    32'(overrun),    32'(exp_ovr));
      check("addr_range", 32'(bus.map_addr < 11'(TILES)), 1);
      if (aq.size() > 0 && aq[0].c == cyc) begin
        check("map_addr", 32'(bus.map_addr), aq[0].a);
        void'(aq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic fill(input logic [1:0] t);
    for (int i = 0; i < TILES; i++) rom[i] = t;
  endtask

  task automatic fill_random();
    for (int i = 0; i < TILES; i++) begin
      int r;
      r = $urandom_range(0, 99);
      rom[i] = (r < 85) ? 2'b00 : (r < 93) ? 2'b01 : 2'(2 + $urandom_range(0, 1));
    end
  endtask

  // One sweep. Called in the drive phase (posedge + 2).
  // Returns in the drive phase of the probe_done cycle.
  task automatic run_sweep(input int bx, input int by);
    int lat;
    BallX       = 10'(bx);
    BallY       = 10'(by);
    frame_start = 1;
    tick(1);
    frame_start = 0;
    BallX = 10'($urandom);   // the sweep must keep using the latched position
    BallY = 10'($urandom);
    lat   = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge Clk);
      #1;
      if (probe_done) lat = k;
    end
    #1;
    check("done_latency", lat, NP + 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int done_cnt;
    Clk = 0;
    Reset_n = 1;
    frame_start = 0;
    BallX = 0;
    BallY = 0;
    fill(2'b00);
    #1 Reset_n = 0;
    cmp_en = 1;
    tick(3);
    check("reset_codes", codes(), 0);
    check("reset_done",  32'(probe_done), 0);
    check("reset_ovr",   32'(overrun), 0);
    check("reset_addr",  32'(bus.map_addr), 0);
    Reset_n = 1;
    tick(2);

    // Empty map: all sides clear.
    run_sweep(320, 240);
    check("empty_map", codes(), 32'o1111);

    // Solid column at tile col 18; the left probe x = 303 lands in it.
    fill(2'b00);
    for (int r = 0; r < 30; r++) rom[r * 40 + 18] = 2'b01;
    run_sweep(319, 240);
    check("solid_col18", codes(), 32'o0111);

    // Hazard under the player, then solid beside it (solid wins).
    fill(2'b00);
    rom[15 * 40 + 20] = 2'b10;
    run_sweep(320, 226);
    check("hazard_below", codes(), 32'o1112);
    rom[15 * 40 + 19] = 2'b01;
    run_sweep(320, 226);
    check("solid_over_hazard", codes(), 32'o1110);

    // Screen edges are solid.
    fill(2'b00);
    run_sweep(10, 240);
    check("offscreen_left", codes(), 32'o0100);
    run_sweep(320, 470);
    check("offscreen_bottom", codes(), 32'o0010);

    // Ledge seen only by the left midpoint.
    fill(2'b00);
    rom[14 * 40 + 19] = 2'b01;
    run_sweep(320, 232);
    check("mid_ledge", codes(), LEDGE_CODES);

    // Randomized maps and positions.
    for (int n = 0; n < 60; n++) begin
      int bx, by;
      fill_random();
      bx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 639);
      by = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 479);
      run_sweep(bx, by);
      tick($urandom_range(0, 3));
    end

    // Second frame_start four edges into a sweep.
    fill(2'b00);
    BallX = 320;
    BallY = 240;
    frame_start = 1;
    tick(1);
    frame_start = 0;
    tick(3);
    frame_start = 1;
    tick(1);
    frame_start = 0;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk);
      #1;
      done_cnt += int'(probe_done);
    end
    #1;
    check("overrun_done_count", done_cnt, 1);
    check("overrun_flag", 32'(overrun), 1);

    // Reset in the middle of a sweep.
    rom[15 * 40 + 21] = 2'b01;
    frame_start = 1;
    tick(1);
    frame_start = 0;
    tick(4);
    Reset_n = 0;
    tick(1);
    check("midreset_codes", codes(), 0);
    check("midreset_ovr",   32'(overrun), 0);
    check("midreset_done",  32'(probe_done), 0);
    Reset_n = 1;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk);
      #1;
      done_cnt += int'(probe_done);
    end
    #1;
    check("no_done_after_reset", done_cnt, 0);

    fill(2'b00);
    run_sweep(320, 240);
    check("sweep_after_reset", codes(), 32'o1111);
    check("ovr_after_reset", 32'(overrun), 0);

    tick(3);
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
